// File: rtl/bus_defs_pkg.sv
// Shared bus definitions: controller FSM encodings and default serial-protocol widths.
// Imported by the arbiter, master and slave RTL.
package bus_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SID     = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_RELEASE = 3'd4
  } bus_state_e;

  localparam int SID_W_DEF       = 3;
  localparam int TIMEOUT_LEN_DEF = 6;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational winner selection: fixed priority (index 0 highest) or round-robin
// starting just after the pointer, wrapping.
module rr_priority_pick #(
  parameter int NUM_MASTERS = 12,
  parameter int MID_W       = 4
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MID_W-1:0]       ptr,
  input  logic                   mode,
  output logic [MID_W-1:0]       winner,
  output logic                   valid
);

  always_comb begin
    int                       base;
    int                       sum;
    logic [2*NUM_MASTERS-1:0] dbl;
    logic [NUM_MASTERS-1:0]   rot;
    winner = '0;
    valid  = 1'b0;
    sum    = 0;
    base   = mode ? int'(ptr) + 1 : 0;
    if (base >= NUM_MASTERS) base = 0;
    // Rotating a doubled copy puts the search start at bit 0 for both modes.
    dbl = {req, req} >> base;
    rot = dbl[NUM_MASTERS-1:0];
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        sum   = base + i;
        if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
        winner = sum[MID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_param.sv
// Parametrised bus controller: arbitrates masters, captures the serial slave ID,
// checks slave availability and supervises the transfer with a timeout.
module bus_arbiter_param
  import bus_defs_pkg::*;
#(
  parameter int NUM_MASTERS = 12,
  parameter int NUM_SLAVES  = 6,
  parameter int SID_W       = SID_W_DEF,
  parameter int TIMEOUT_LEN = TIMEOUT_LEN_DEF,
  parameter int MID_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arb_mode,
  input  logic [NUM_MASTERS-1:0] m_reqs,
  output logic [NUM_MASTERS-1:0] m_grants,
  input  logic                   b_bus,
  input  logic                   b_bus_util,
  input  logic [NUM_SLAVES-1:0]  slaves_busy,
  output logic [NUM_SLAVES-1:0]  slaves_sel,
  output logic [MID_W-1:0]       mid_current,
  output logic [2:0]             state,
  output logic                   reject_p,
  output logic                   timeout_p
);

  localparam int                     SC_W     = $clog2(SID_W) + 1;
  localparam logic [SC_W-1:0]        SID_LAST = SC_W'(SID_W - 1);
  // Compare against limit-1 so the pulse lands on the edge where the count reaches the limit.
  localparam logic [TIMEOUT_LEN-1:0] TMO_LAST = {{(TIMEOUT_LEN-1){1'b1}}, 1'b0};

  bus_state_e             state_q, state_d;
  logic [SID_W-1:0]       sid_reg, sid_d;
  logic [SC_W-1:0]        sid_cnt, sid_cnt_d;
  logic [TIMEOUT_LEN-1:0] tmo_cnt, tmo_d;
  logic [MID_W-1:0]       rr_ptr, ptr_d;
  logic                   util_p1;
  logic [NUM_MASTERS-1:0] grants_d, pick_hot;
  logic [NUM_SLAVES-1:0]  sel_d, sid_hot;
  logic [MID_W-1:0]       mid_d, pick_idx;
  logic                   reject_d, timeout_d, pick_vld;
  logic                   req_cur, util_rise, sid_ok;

  rr_priority_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .MID_W      (MID_W)
  ) u_pick (
    .req   (m_reqs),
    .ptr   (rr_ptr),
    .mode  (arb_mode),
    .winner(pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    pick_hot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) pick_hot[i] = (int'(pick_idx) == i);
  end

  always_comb begin
    sid_hot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) sid_hot[i] = (int'(sid_reg) == i);
  end

  // The grant vector is one-hot, so masking with it yields the granted master's request.
  assign req_cur   = |(m_reqs & m_grants);
  assign util_rise = b_bus_util & ~util_p1;
  assign sid_ok    = (int'(sid_reg) < NUM_SLAVES) && !(|(sid_hot & slaves_busy));
  assign state     = state_q;

  always_comb begin
    state_d   = state_q;
    grants_d  = m_grants;
    sel_d     = slaves_sel;
    mid_d     = mid_current;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    sid_d     = sid_reg;
    sid_cnt_d = sid_cnt;
    tmo_d     = tmo_cnt;
    ptr_d     = rr_ptr;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grants_d  = pick_hot;
          mid_d     = pick_idx;
          sid_cnt_d = '0;
          state_d   = ST_SID;
        end
      end
      ST_SID: begin
        if (!req_cur) begin
          state_d = ST_RELEASE;
        end else begin
          sid_d     = (sid_reg << 1) | SID_W'(b_bus);
          sid_cnt_d = sid_cnt + 1'b1;
          if (sid_cnt == SID_LAST) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        tmo_d = '0;
        if (sid_ok) begin
          sel_d   = sid_hot;
          state_d = ST_ACTIVE;
        end else begin
          reject_d = 1'b1;
          state_d  = ST_RELEASE;
        end
      end
      ST_ACTIVE: begin
        // Completion (edge or request drop) outranks a coincident timeout.
        if (util_rise || !req_cur) begin
          state_d = ST_RELEASE;
        end else if (b_bus_util && tmo_cnt == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          tmo_d = b_bus_util ? tmo_cnt + 1'b1 : '0;
        end
      end
      ST_RELEASE: begin
        grants_d = '0;
        sel_d    = '0;
        mid_d    = '0;
        tmo_d    = '0;
        ptr_d    = mid_current;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      m_grants    <= '0;
      slaves_sel  <= '0;
      mid_current <= '0;
      reject_p    <= 1'b0;
      timeout_p   <= 1'b0;
      sid_cnt     <= '0;
      tmo_cnt     <= '0;
      rr_ptr      <= MID_W'(NUM_MASTERS - 1);
      util_p1     <= 1'b1;
    end else begin
      state_q     <= state_d;
      m_grants    <= grants_d;
      slaves_sel  <= sel_d;
      mid_current <= mid_d;
      reject_p    <= reject_d;
      timeout_p   <= timeout_d;
      sid_cnt     <= sid_cnt_d;
      tmo_cnt     <= tmo_d;
      rr_ptr      <= ptr_d;
      util_p1     <= b_bus_util;
    end
  end

  always_ff @(posedge clk) begin
    sid_reg <= sid_d;
  end

endmodule

// File: tb/tb_bus_arbiter_param.sv
// Directed bench for bus_arbiter_param: arbitration order, slave-ID capture,
// reject, timeout, completion and reset scenarios.
module tb_bus_arbiter_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_mode;
  logic [11:0] m_reqs;
  logic [11:0] m_grants;
  logic        b_bus;
  logic        b_bus_util;
  logic [5:0]  slaves_busy;
  logic [5:0]  slaves_sel;
  logic [3:0]  mid_current;
  logic [2:0]  state;
  logic        reject_p;
  logic        timeout_p;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter_param dut (
    .clk        (clk),
    .rst        (rst),
    .arb_mode   (arb_mode),
    .m_reqs     (m_reqs),
    .m_grants   (m_grants),
    .b_bus      (b_bus),
    .b_bus_util (b_bus_util),
    .slaves_busy(slaves_busy),
    .slaves_sel (slaves_sel),
    .mid_current(mid_current),
    .state      (state),
    .reject_p   (reject_p),
    .timeout_p  (timeout_p)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arb_mode    = 1'b0;
    m_reqs      = '0;
    b_bus       = 1'b1;
    b_bus_util  = 1'b1;
    slaves_busy = '0;
    rst         = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_grants != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_sid(input logic [2:0] sid);
    for (int b = 2; b >= 0; b--) begin
      b_bus = sid[b];
      tick();
    end
    b_bus = 1'b1;
  endtask

  task automatic finish_transfer();
    b_bus_util = 1'b0;
    tick();
    b_bus_util = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    n_checks++; if ({m_grants, slaves_sel, mid_current, state, reject_p, timeout_p} !== '0) begin n_fail++; $display("FAIL reset_init: grants=%h sel=%b mid=%0d state=%0d expected all 0", m_grants, slaves_sel, mid_current, state); end
    m_reqs = 12'h004;
    wait_grant(ok);
    send_sid(3'd0);
    tick();
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL reset_pre_active: state=%0d expected 3", state); end
    rst = 1'b1;
    tick();
    n_checks++; if ({m_grants, slaves_sel, mid_current, state, reject_p, timeout_p} !== '0) begin n_fail++; $display("FAIL reset_mid_active: grants=%h sel=%b mid=%0d state=%0d expected all 0", m_grants, slaves_sel, mid_current, state); end
    tick();
    tick();
    m_reqs = '0;
    rst    = 1'b0;
    tick();
    tick();
    n_checks++; if ({m_grants, slaves_sel, mid_current, state, reject_p, timeout_p} !== '0) begin n_fail++; $display("FAIL reset_after: grants=%h sel=%b mid=%0d state=%0d expected all 0", m_grants, slaves_sel, mid_current, state); end
  endtask

  task automatic test_basic();
    do_reset();
    m_reqs = 12'h024;
    tick();
    n_checks++; if (m_grants !== 12'h004 || mid_current !== 4'd2 || state !== 3'd1) begin n_fail++; $display("FAIL basic_grant: grants=%h mid=%0d state=%0d expected 004/2/1", m_grants, mid_current, state); end
    send_sid(3'b011);
    n_checks++; if (state !== 3'd2 || slaves_sel !== 6'b0) begin n_fail++; $display("FAIL basic_check: state=%0d sel=%b expected 2/000000", state, slaves_sel); end
    tick();
    n_checks++; if (state !== 3'd3 || slaves_sel !== 6'b001000 || m_grants !== 12'h004) begin n_fail++; $display("FAIL basic_select: state=%0d sel=%b grants=%h expected 3/001000/004", state, slaves_sel, m_grants); end
    finish_transfer();
    n_checks++; if (state !== 3'd4 || timeout_p !== 1'b0 || m_grants !== 12'h004) begin n_fail++; $display("FAIL basic_release: state=%0d tmo=%b grants=%h expected 4/0/004", state, timeout_p, m_grants); end
    m_reqs = '0;
    tick();
    n_checks++; if (state !== 3'd0 || m_grants !== '0 || slaves_sel !== '0 || mid_current !== '0) begin n_fail++; $display("FAIL basic_idle: state=%0d grants=%h sel=%b mid=%0d expected all 0", state, m_grants, slaves_sel, mid_current); end
  endtask

  task automatic test_order(input logic mode, input int nxfer, input int exp0, input int exp1, input int exp2, input int exp3);
    int exp_ord[4];
    bit ok;
    exp_ord = '{exp0, exp1, exp2, exp3};
    do_reset();
    arb_mode = mode;
    m_reqs   = 12'h034;
    for (int k = 0; k < nxfer; k++) begin
      wait_grant(ok);
      n_checks++; if (!ok || mid_current !== 4'(exp_ord[k]) || m_grants !== (12'h1 << exp_ord[k])) begin n_fail++; $display("FAIL order_m%0d_x%0d: mid=%0d grants=%h expected %0d", mode, k, mid_current, m_grants, exp_ord[k]); end
      send_sid(3'd0);
      tick();
      finish_transfer();
      tick();
    end
    m_reqs = '0;
    tick();
  endtask

  task automatic test_reject();
    bit ok;
    do_reset();
    m_reqs = 12'h004;
    wait_grant(ok);
    send_sid(3'b110);
    tick();
    n_checks++; if (!ok || reject_p !== 1'b1 || slaves_sel !== '0 || state !== 3'd4 || m_grants !== 12'h004) begin n_fail++; $display("FAIL reject_range: rej=%b sel=%b state=%0d grants=%h expected 1/0/4/004", reject_p, slaves_sel, state, m_grants); end
    m_reqs = '0;
    tick();
    n_checks++; if (reject_p !== 1'b0 || m_grants !== '0 || state !== 3'd0) begin n_fail++; $display("FAIL reject_range_clr: rej=%b grants=%h state=%0d expected 0/000/0", reject_p, m_grants, state); end
    slaves_busy = 6'b001000;
    m_reqs      = 12'h004;
    wait_grant(ok);
    send_sid(3'd3);
    tick();
    n_checks++; if (!ok || reject_p !== 1'b1 || slaves_sel !== '0 || state !== 3'd4) begin n_fail++; $display("FAIL reject_busy: rej=%b sel=%b state=%0d expected 1/0/4", reject_p, slaves_sel, state); end
    m_reqs = '0;
    tick();
    n_checks++; if (reject_p !== 1'b0 || m_grants !== '0) begin n_fail++; $display("FAIL reject_busy_clr: rej=%b grants=%h expected 0/000", reject_p, m_grants); end
    slaves_busy = '0;
  endtask

  task automatic test_timeout();
    bit ok;
    bit early;
    do_reset();
    m_reqs = 12'h004;
    wait_grant(ok);
    send_sid(3'd1);
    tick();
    early = 1'b0;
    for (int i = 1; i <= 62; i++) begin
      tick();
      if (timeout_p || state !== 3'd3) early = 1'b1;
    end
    n_checks++; if (!ok || early) begin n_fail++; $display("FAIL timeout_early: got early exit or pulse=%b, expected none before cycle 63", early); end
    tick();
    n_checks++; if (timeout_p !== 1'b1 || state !== 3'd4) begin n_fail++; $display("FAIL timeout_pulse: tmo=%b state=%0d expected 1/4", timeout_p, state); end
    m_reqs = '0;
    tick();
    n_checks++; if (timeout_p !== 1'b0 || m_grants !== '0 || state !== 3'd0) begin n_fail++; $display("FAIL timeout_clr: tmo=%b grants=%h state=%0d expected 0/000/0", timeout_p, m_grants, state); end
  endtask

  task automatic test_util_pulse(input int low_at);
    bit ok;
    bit early;
    do_reset();
    m_reqs = 12'h004;
    wait_grant(ok);
    send_sid(3'd1);
    tick();
    early = 1'b0;
    for (int i = 1; i < low_at; i++) begin
      tick();
      if (timeout_p || state !== 3'd3) early = 1'b1;
    end
    b_bus_util = 1'b0;
    tick();
    if (timeout_p || state !== 3'd3) early = 1'b1;
    b_bus_util = 1'b1;
    tick();
    n_checks++; if (!ok || early || state !== 3'd4 || timeout_p !== 1'b0) begin n_fail++; $display("FAIL util_pulse_%0d: early=%b state=%0d tmo=%b expected 0/4/0", low_at, early, state, timeout_p); end
    m_reqs = '0;
    tick();
    n_checks++; if (m_grants !== '0 || timeout_p !== 1'b0 || state !== 3'd0) begin n_fail++; $display("FAIL util_pulse_%0d_clr: grants=%h tmo=%b state=%0d expected 000/0/0", low_at, m_grants, timeout_p, state); end
  endtask

  task automatic test_req_drop();
    bit ok;
    do_reset();
    m_reqs = 12'h004;
    wait_grant(ok);
    b_bus = 1'b0;
    tick();
    m_reqs = '0;
    tick();
    n_checks++; if (!ok || state !== 3'd4 || reject_p !== 1'b0) begin n_fail++; $display("FAIL drop_sid: state=%0d rej=%b expected 4/0", state, reject_p); end
    tick();
    n_checks++; if (state !== 3'd0 || m_grants !== '0) begin n_fail++; $display("FAIL drop_sid_clr: state=%0d grants=%h expected 0/000", state, m_grants); end
    m_reqs = 12'h800;
    wait_grant(ok);
    send_sid(3'd5);
    tick();
    n_checks++; if (!ok || state !== 3'd3 || slaves_sel !== 6'b100000 || mid_current !== 4'd11) begin n_fail++; $display("FAIL drop_active_sel: state=%0d sel=%b mid=%0d expected 3/100000/11", state, slaves_sel, mid_current); end
    m_reqs = '0;
    tick();
    n_checks++; if (state !== 3'd4 || timeout_p !== 1'b0) begin n_fail++; $display("FAIL drop_active: state=%0d tmo=%b expected 4/0", state, timeout_p); end
    tick();
    n_checks++; if (m_grants !== '0 || slaves_sel !== '0 || mid_current !== '0) begin n_fail++; $display("FAIL drop_active_clr: grants=%h sel=%b mid=%0d expected all 0", m_grants, slaves_sel, mid_current); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order(1'b1, 4, 2, 4, 5, 2);
    test_order(1'b0, 3, 2, 2, 2, 0);
    test_reject();
    test_timeout();
    test_util_pulse(40);
    test_util_pulse(62);
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
